// File: rtl/ocp_if.sv
// OCP bus bundle shared by the two upstream requesters and the downstream slave.
// m_* signals flow from requester to target, s_* signals flow back.
interface ocp_if #(
  parameter int TAGI_WIDTH = 5,
  parameter int INFO_WIDTH = 4,
  parameter int BLEN_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // command phase
  logic [2:0]            m_cmd;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [BLEN_WIDTH-1:0] m_burst_length;
  logic [2:0]            m_burst_seq;
  logic [BE_WIDTH-1:0]   m_byteen;
  logic [INFO_WIDTH-1:0] m_req_info;
  logic [TAGI_WIDTH-1:0] m_tagid;
  logic                  s_cmd_accept;
  // write data phase
  logic [DATA_WIDTH-1:0] m_data;
  logic [BE_WIDTH-1:0]   m_data_byteen;
  logic                  m_data_valid;
  logic                  m_data_last;
  logic [TAGI_WIDTH-1:0] m_data_tagid;
  logic                  s_data_accept;
  // response phase
  logic [1:0]            s_resp;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_resp_last;
  logic [TAGI_WIDTH-1:0] s_tagid;
  logic                  m_resp_accept;

  modport master (
    output m_cmd, m_addr, m_burst_length, m_burst_seq, m_byteen, m_req_info, m_tagid,
           m_data, m_data_byteen, m_data_valid, m_data_last, m_data_tagid, m_resp_accept,
    input  s_cmd_accept, s_data_accept, s_resp, s_data, s_resp_last, s_tagid
  );

  modport slave (
    input  m_cmd, m_addr, m_burst_length, m_burst_seq, m_byteen, m_req_info, m_tagid,
           m_data, m_data_byteen, m_data_valid, m_data_last, m_data_tagid, m_resp_accept,
    output s_cmd_accept, s_data_accept, s_resp, s_data, s_resp_last, s_tagid
  );
endinterface

// File: rtl/ocp_arb2.sv
// Two-requester round-robin OCP arbiter. Commands and write bursts are
// serialised onto one downstream port; the grant index is stamped into the
// tag MSB so responses can be steered back without involving the FSM.
module ocp_arb2 #(
  parameter int TAGI_WIDTH = 5,
  parameter int INFO_WIDTH = 4,
  parameter int BLEN_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  ocp_if.slave       up0,
  ocp_if.slave       up1,
  ocp_if.master      dn,
  output logic [1:0] gnt,
  output logic       err
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA} state_t;

  state_t                state;
  logic [1:0]            gnt_q;
  logic                  last1;      // 1 when requester 1 was granted most recently
  logic [BLEN_WIDTH-1:0] blen_q;
  logic [BLEN_WIDTH-1:0] beat_cnt;

  // granted-side view of the upstream request
  logic                  gidx;
  logic [2:0]            sel_cmd;
  logic [BLEN_WIDTH-1:0] sel_blen;
  logic [TAGI_WIDTH-1:0] sel_tag;
  logic [TAGI_WIDTH-1:0] sel_dtag;
  logic                  sel_dvalid;
  logic                  sel_dlast;

  logic pend0, pend1, in_cmd, in_wd, cmd_hs, beat_hs, dn_last, bad_cmd, err_now;

  assign gidx       = gnt_q[1];
  assign sel_cmd    = gidx ? up1.m_cmd          : up0.m_cmd;
  assign sel_blen   = gidx ? up1.m_burst_length : up0.m_burst_length;
  assign sel_tag    = gidx ? up1.m_tagid        : up0.m_tagid;
  assign sel_dtag   = gidx ? up1.m_data_tagid   : up0.m_data_tagid;
  assign sel_dvalid = gidx ? up1.m_data_valid   : up0.m_data_valid;
  assign sel_dlast  = gidx ? up1.m_data_last    : up0.m_data_last;

  assign pend0   = up0.m_cmd != CMD_IDLE;
  assign pend1   = up1.m_cmd != CMD_IDLE;
  // rst_n gating keeps every handshake quiet while reset is held
  assign in_cmd  = rst_n && (state == S_CMD);
  assign in_wd   = rst_n && (state == S_WDATA);
  assign cmd_hs  = in_cmd && dn.s_cmd_accept;
  assign beat_hs = in_wd && sel_dvalid && dn.s_data_accept;
  assign dn_last = in_wd && (beat_cnt + BLEN_WIDTH'(1) == blen_q);
  assign bad_cmd = (sel_cmd != CMD_IDLE) && (sel_cmd != CMD_WR) && (sel_cmd != CMD_RD);

  assign err_now = (cmd_hs && (bad_cmd || sel_tag[TAGI_WIDTH-1] ||
                               ((sel_cmd == CMD_WR) && (sel_blen == '0)))) ||
                   (beat_hs && ((sel_dlast != dn_last) || sel_dtag[TAGI_WIDTH-1]));

  // command phase towards the shared slave; unknown commands go out as reads
  assign dn.m_cmd          = !in_cmd ? CMD_IDLE : (bad_cmd ? CMD_RD : sel_cmd);
  assign dn.m_addr         = gidx ? up1.m_addr       : up0.m_addr;
  assign dn.m_burst_length = sel_blen;
  assign dn.m_burst_seq    = gidx ? up1.m_burst_seq  : up0.m_burst_seq;
  assign dn.m_byteen       = gidx ? up1.m_byteen     : up0.m_byteen;
  assign dn.m_req_info     = gidx ? up1.m_req_info   : up0.m_req_info;
  assign dn.m_tagid        = {gidx, sel_tag[TAGI_WIDTH-2:0]};
  assign up0.s_cmd_accept  = in_cmd && gnt_q[0] && dn.s_cmd_accept;
  assign up1.s_cmd_accept  = in_cmd && gnt_q[1] && dn.s_cmd_accept;

  // write data phase; last is generated from our own beat count
  assign dn.m_data         = gidx ? up1.m_data        : up0.m_data;
  assign dn.m_data_byteen  = gidx ? up1.m_data_byteen : up0.m_data_byteen;
  assign dn.m_data_valid   = in_wd && sel_dvalid;
  assign dn.m_data_last    = dn_last;
  assign dn.m_data_tagid   = {gidx, sel_dtag[TAGI_WIDTH-2:0]};
  assign up0.s_data_accept = in_wd && gnt_q[0] && dn.s_data_accept;
  assign up1.s_data_accept = in_wd && gnt_q[1] && dn.s_data_accept;

  // response phase, steered purely by the returned tag MSB
  logic rsel;
  assign rsel             = dn.s_tagid[TAGI_WIDTH-1];
  assign up0.s_resp       = rsel ? 2'b00 : dn.s_resp;
  assign up1.s_resp       = rsel ? dn.s_resp : 2'b00;
  assign up0.s_data       = dn.s_data;
  assign up1.s_data       = dn.s_data;
  assign up0.s_resp_last  = dn.s_resp_last;
  assign up1.s_resp_last  = dn.s_resp_last;
  assign up0.s_tagid      = {1'b0, dn.s_tagid[TAGI_WIDTH-2:0]};
  assign up1.s_tagid      = {1'b0, dn.s_tagid[TAGI_WIDTH-2:0]};
  assign dn.m_resp_accept = rst_n && (dn.s_resp != 2'b00) &&
                            (rsel ? up1.m_resp_accept : up0.m_resp_accept);

  assign gnt = gnt_q;

  // arbitration / burst sequencing FSM with registered grant and error pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      gnt_q    <= 2'b00;
      last1    <= 1'b1;
      blen_q   <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= err_now;
      case (state)
        S_IDLE: begin
          if (pend0 || pend1) begin
            state <= S_CMD;
            if (pend0 && (!pend1 || last1)) begin
              gnt_q <= 2'b01;
              last1 <= 1'b0;
            end else begin
              gnt_q <= 2'b10;
              last1 <= 1'b1;
            end
          end
        end
        S_CMD: begin
          if (dn.s_cmd_accept) begin
            if (sel_cmd == CMD_WR) begin
              state    <= S_WDATA;
              blen_q   <= (sel_blen == '0) ? BLEN_WIDTH'(1) : sel_blen;
              beat_cnt <= '0;
            end else begin
              state <= S_IDLE;
              gnt_q <= 2'b00;
            end
          end
        end
        S_WDATA: begin
          if (beat_hs) begin
            beat_cnt <= beat_cnt + BLEN_WIDTH'(1);
            if (dn_last) begin
              state <= S_IDLE;
              gnt_q <= 2'b00;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          gnt_q <= 2'b00;
        end
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{BE_WIDTH, INFO_WIDTH, ADDR_WIDTH, DATA_WIDTH};
endmodule
